// File: rtl/sl_obi_wbuf_pkg.sv
// Shared types for the serial-link OBI write buffer.
//   sl_obi_req_t / sl_obi_rsp_t : default OBI request/response structs
//   wbuf_entry_t                : one buffered write {addr, be, wdata}
//   wbuf_state_e                : master-side FSM states
package sl_obi_wbuf_pkg;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiBeWidth   = ObiDataWidth / 8;

  typedef struct packed {
    logic                    req;
    logic [ObiAddrWidth-1:0] addr;
    logic                    we;
    logic [ObiBeWidth-1:0]   be;
    logic [ObiDataWidth-1:0] wdata;
  } sl_obi_req_t;

  typedef struct packed {
    logic                    gnt;
    logic                    rvalid;
    logic [ObiDataWidth-1:0] rdata;
  } sl_obi_rsp_t;

  typedef struct packed {
    logic [ObiAddrWidth-1:0] addr;
    logic [ObiBeWidth-1:0]   be;
    logic [ObiDataWidth-1:0] wdata;
  } wbuf_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP
  } wbuf_state_e;

endpackage

// File: rtl/sl_obi_wbuf_fifo.sv
// Write-entry FIFO for the OBI write buffer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write an entry (caller guarantees not full)
//   pop_i/data_o  : head entry, removed on pop_i (caller guarantees not empty)
//   count_o       : registered occupancy, full_o / empty_o derived from it
module sl_obi_wbuf_fifo
  import sl_obi_wbuf_pkg::*;
#(
  parameter  int unsigned Depth    = 8,
  localparam int unsigned PtrWidth = $clog2(Depth),
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  wbuf_entry_t         data_i,
  input  logic                pop_i,
  output wbuf_entry_t         data_o,
  output logic [CntWidth-1:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  wbuf_entry_t         mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; count and pointers decide validity, so stale entries are never read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntWidth'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/sl_obi_write_buffer.sv
// Posted-write buffer between a core/DMA OBI port and the serial-link OBI port.
// Writes are granted immediately while space remains and acknowledged one
// cycle later; reads wait until every buffered write has completed on the
// master side and then pass through with a combinational rvalid/rdata path.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   slv_req_i / slv_rsp_o  : OBI slave port (core/DMA side)
//   mst_req_o / mst_rsp_i  : OBI master port (serial-link side)
//   empty_o                : FIFO empty and master FSM idle
//   full_o                 : FIFO holds Depth entries
//   hwm_o                  : high-water mark of FIFO occupancy, present only
//                            when SL_WBUF_HWM_EN is defined
module sl_obi_write_buffer
  import sl_obi_wbuf_pkg::*;
#(
  parameter  type         obi_req_t  = sl_obi_req_t,
  parameter  type         obi_resp_t = sl_obi_rsp_t,
  parameter  int unsigned Depth      = 8,
  parameter  int unsigned AddrWidth  = 32,
  parameter  int unsigned DataWidth  = 32,
  localparam int unsigned CntWidth   = $clog2(Depth + 1)
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  slv_req_i,
  output obi_resp_t slv_rsp_o,
  output obi_req_t  mst_req_o,
  input  obi_resp_t mst_rsp_i,
  output logic      empty_o,
  output logic      full_o
`ifdef SL_WBUF_HWM_EN
  ,
  output logic [CntWidth-1:0] hwm_o
`endif
);

  localparam int unsigned BeWidth = DataWidth / 8;

  wbuf_state_e         state_q;
  obi_req_t            mst_req_q;
  logic                wr_rvalid_q;
  wbuf_entry_t         push_entry, head_entry;
  logic [CntWidth-1:0] fifo_count;
  logic                fifo_full, fifo_empty;
  logic                rd_busy, wr_gnt, rd_gnt, pop;

  assign rd_busy = (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);
  assign empty_o = fifo_empty && (state_q == ST_IDLE);
  assign full_o  = fifo_full;

  // Admission looks at the registered count only, so a pop in the same cycle
  // does not open a slot. Gnt is gated by rst_ni so the slave port reads
  // all-zero while reset is asserted.
  assign wr_gnt = rst_ni && slv_req_i.req && slv_req_i.we &&
                  (fifo_count < CntWidth'(Depth)) && !rd_busy;
  assign rd_gnt = rst_ni && slv_req_i.req && !slv_req_i.we && empty_o;
  assign pop    = (state_q == ST_WR_REQ) && mst_rsp_i.gnt;

  always_comb begin
    push_entry.addr  = slv_req_i.addr[AddrWidth-1:0];
    push_entry.be    = slv_req_i.be[BeWidth-1:0];
    push_entry.wdata = slv_req_i.wdata[DataWidth-1:0];
  end

  sl_obi_wbuf_fifo #(
    .Depth (Depth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_gnt),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Master FSM: one outstanding transaction. The request register is loaded
  // on entry to WR_REQ/RD_REQ and held until gnt, keeping all fields stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mst_req_q   <= '0;
      wr_rvalid_q <= 1'b0;
    end else begin
      wr_rvalid_q <= wr_gnt;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q         <= ST_WR_REQ;
            mst_req_q.req   <= 1'b1;
            mst_req_q.we    <= 1'b1;
            mst_req_q.addr  <= head_entry.addr;
            mst_req_q.be    <= head_entry.be;
            mst_req_q.wdata <= head_entry.wdata;
          end else if (rd_gnt) begin
            state_q         <= ST_RD_REQ;
            mst_req_q.req   <= 1'b1;
            mst_req_q.we    <= 1'b0;
            mst_req_q.addr  <= slv_req_i.addr;
            mst_req_q.be    <= slv_req_i.be;
            mst_req_q.wdata <= '0;
          end
        end
        ST_WR_REQ: begin
          if (mst_rsp_i.gnt) begin
            state_q   <= ST_WR_RESP;
            mst_req_q <= '0;
          end
        end
        ST_WR_RESP: begin
          if (mst_rsp_i.rvalid) state_q <= ST_IDLE;
        end
        ST_RD_REQ: begin
          if (mst_rsp_i.gnt) begin
            state_q   <= ST_RD_RESP;
            mst_req_q <= '0;
          end
        end
        ST_RD_RESP: begin
          if (mst_rsp_i.rvalid) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mst_req_o = mst_req_q;

  // Write acknowledges come from a register; read data is forwarded straight
  // from the master port while the read is outstanding.
  always_comb begin
    slv_rsp_o     = '0;
    slv_rsp_o.gnt = wr_gnt || rd_gnt;
    if (state_q == ST_RD_RESP) begin
      slv_rsp_o.rvalid = mst_rsp_i.rvalid;
      slv_rsp_o.rdata  = mst_rsp_i.rdata;
    end else begin
      slv_rsp_o.rvalid = wr_rvalid_q;
    end
  end

`ifdef SL_WBUF_HWM_EN
  logic [CntWidth-1:0] hwm_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hwm_q <= '0;
    end else if (fifo_count > hwm_q) begin
      hwm_q <= fifo_count;
    end
  end

  assign hwm_o = hwm_q;
`endif

endmodule

// File: tb/tb_sl_obi_write_buffer.sv
// Self-checking bench for sl_obi_write_buffer: a randomised OBI memory
// device on the master port, a reference memory updated at slave-side
// acceptance, and scoreboard queues checked by an independent monitor.
module tb_sl_obi_write_buffer;
  import sl_obi_wbuf_pkg::*;

  localparam int Depth  = 8;
  localparam int CntW   = $clog2(Depth + 1);
  localparam int Budget = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  sl_obi_req_t slv_req = '0;
  sl_obi_req_t mst_req;
  sl_obi_rsp_t slv_rsp;
  sl_obi_rsp_t mst_rsp = '0;
  logic        empty, full;
`ifdef SL_WBUF_HWM_EN
  logic [CntW-1:0] hwm;
`endif

  sl_obi_write_buffer #(
    .obi_req_t  (sl_obi_req_t),
    .obi_resp_t (sl_obi_rsp_t),
    .Depth      (Depth),
    .AddrWidth  (32),
    .DataWidth  (32)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .slv_req_i (slv_req),
    .slv_rsp_o (slv_rsp),
    .mst_req_o (mst_req),
    .mst_rsp_i (mst_rsp),
    .empty_o   (empty),
    .full_o    (full)
`ifdef SL_WBUF_HWM_EN
    ,
    .hwm_o     (hwm)
`endif
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    int          due;
  } rsp_exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mst_exp_t;

  rsp_exp_t    slv_q[$];
  mst_exp_t    mst_q[$];
  logic [31:0] ref_mem [bit [31:0]];
  logic [31:0] dev_mem [bit [31:0]];

  int n_checks = 0, n_fail = 0;
  int gnt_pct = 100, max_lat = 0;
  int wr_accepted = 0, wr_done = 0;
  int last_wr_rv_cycle = -1, last_hs_cycle = -1, mst_req_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    return r;
  endfunction

  // OBI memory device on the master port: random gnt, random rvalid latency.
  initial begin : responder
    bit          hs, pend, pend_we;
    int          delay;
    logic [31:0] pend_rdata, old;
    sl_obi_req_t cap;
    pend = 0;
    pend_we = 0;
    delay = 0;
    pend_rdata = '0;
    forever begin
      @(negedge clk);
      hs  = rst_n && mst_req.req && mst_rsp.gnt;
      cap = mst_req;
      if (hs) last_hs_cycle = cycle;
      if (rst_n && mst_req.req) mst_req_cycles++;
      @(posedge clk);
      #1;
      mst_rsp.rvalid = 1'b0;
      mst_rsp.rdata  = '0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (hs) begin
          pend    = 1;
          pend_we = cap.we;
          delay   = $urandom_range(0, max_lat);
          old     = dev_mem.exists(cap.addr) ? dev_mem[cap.addr] : 32'h0;
          if (cap.we) begin
            dev_mem[cap.addr] = merge(old, cap.wdata, cap.be);
            pend_rdata = '0;
          end else begin
            pend_rdata = old;
          end
        end
        if (pend) begin
          if (delay == 0) begin
            mst_rsp.rvalid = 1'b1;
            mst_rsp.rdata  = pend_rdata;
            pend = 0;
            if (pend_we) begin
              wr_done++;
              last_wr_rv_cycle = cycle;
            end
          end else begin
            delay--;
          end
        end
      end
      mst_rsp.gnt = ($urandom_range(0, 99) < gnt_pct);
    end
  end

  // Monitor: compares master handshakes and slave responses against the queues.
  initial begin : monitor
    mst_exp_t m;
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mst_req.req && mst_rsp.gnt) begin
          if (mst_q.size() == 0) begin
            check("mst_unexpected_req", 64'(mst_req.req), 64'(0));
          end else begin
            m = mst_q.pop_front();
            check("mst_we", 64'(mst_req.we), 64'(m.we));
            check("mst_addr", 64'(mst_req.addr), 64'(m.addr));
            if (m.we) begin
              check("mst_wdata", 64'(mst_req.wdata), 64'(m.wdata));
              check("mst_be", 64'(mst_req.be), 64'(m.be));
            end
          end
        end
        if (slv_rsp.rvalid) begin
          if (slv_q.size() == 0) begin
            check("slv_unexpected_rvalid", 64'(slv_rsp.rvalid), 64'(0));
          end else begin
            r = slv_q.pop_front();
            check("slv_rdata", 64'(slv_rsp.rdata), 64'(r.rdata));
            if (r.is_read) check("rd_rvalid_same_cycle", 64'(mst_rsp.rvalid), 64'(1));
            else check("wr_rvalid_cycle", 64'(cycle), 64'(r.due));
          end
        end else if (slv_q.size() != 0 && !slv_q[0].is_read && cycle >= slv_q[0].due) begin
          check("wr_rvalid_missing", 64'(slv_rsp.rvalid), 64'(1));
          void'(slv_q.pop_front());
        end
      end
    end
  end

  // Issue one slave request starting at posedge+1; returns grant cycle and wait count.
  task automatic slv_issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output int gcyc, output int waited);
    logic [31:0] old;
    slv_req.req   = 1'b1;
    slv_req.we    = we;
    slv_req.addr  = addr;
    slv_req.wdata = we ? wdata : 32'h0;
    slv_req.be    = be;
    waited = 0;
    gcyc   = -1;
    forever begin
      @(negedge clk);
      if (slv_rsp.gnt || waited >= Budget) break;
      waited++;
      @(posedge clk);
      #1;
    end
    if (slv_rsp.gnt) begin
      gcyc = cycle;
      old  = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
      if (we) begin
        ref_mem[addr] = merge(old, wdata, be);
        wr_accepted++;
        slv_q.push_back('{is_read: 1'b0, rdata: 32'h0, due: cycle + 1});
        mst_q.push_back('{we: 1'b1, addr: addr, be: be, wdata: wdata});
      end else begin
        check("rd_gnt_after_drain", 64'(wr_done), 64'(wr_accepted));
        check("rd_gnt_after_wr_rvalid", 64'(cycle > last_wr_rv_cycle), 64'(1));
        slv_q.push_back('{is_read: 1'b1, rdata: old, due: 0});
        mst_q.push_back('{we: 1'b0, addr: addr, be: be, wdata: 32'h0});
      end
    end else begin
      check("slv_gnt_timeout", 64'(slv_rsp.gnt), 64'(1));
    end
    @(posedge clk);
    #1;
    slv_req = '0;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (slv_q.size() != 0 && n < Budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(slv_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(empty && slv_q.size() == 0 && mst_q.size() == 0) && n < Budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(empty && slv_q.size() == 0 && mst_q.size() == 0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic set_gnt(input int pct);
    gnt_pct = pct;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          g, w, g9, w9;
    logic [31:0] a;
    bit          rd;

    // Reset state, with a write request presented while reset is held.
    slv_req.req   = 1'b1;
    slv_req.we    = 1'b1;
    slv_req.addr  = 32'h100;
    slv_req.wdata = 32'h1;
    slv_req.be    = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_slv_gnt", 64'(slv_rsp.gnt), 64'(0));
    check("rst_slv_rsp_zero", 64'(slv_rsp == '0), 64'(1));
    check("rst_mst_req_zero", 64'(mst_req == '0), 64'(1));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    slv_req = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three writes with master gnt always high.
    set_gnt(100);
    max_lat = 0;
    for (int i = 0; i < 3; i++) begin
      slv_issue(1'b1, 32'h1000 + 32'(4 * i), 32'hA + 32'(i), 4'hF, g, w);
      check("wr_same_cycle_gnt", 64'(w), 64'(0));
    end
    wait_drain("drain_basic");

    // Fill with master gnt held low: 8 immediate grants, the 9th stalls.
    set_gnt(0);
    for (int i = 0; i < Depth; i++) begin
      slv_issue(1'b1, 32'h1200 + 32'(4 * i), 32'h600 + 32'(i), 4'hF, g, w);
      check("fill_same_cycle_gnt", 64'(w), 64'(0));
    end
    check("full_after_fill", 64'(full), 64'(1));
    check("not_empty_after_fill", 64'(empty), 64'(0));
    fork
      slv_issue(1'b1, 32'h1220, 32'h608, 4'hF, g9, w9);
      begin
        repeat (6) @(negedge clk);
        gnt_pct = 100;
      end
    join
    check("ninth_gnt_after_first_mst_gnt", 64'(g9), 64'(last_hs_cycle + 1));
    wait_drain("drain_fill");
    check("not_full_after_drain", 64'(full), 64'(0));

    // Writes then a read that must wait for them to drain.
    set_gnt(70);
    max_lat = 2;
    dev_mem[32'h2000] = 32'h55;
    ref_mem[32'h2000] = 32'h55;
    slv_issue(1'b1, 32'h1100, 32'h11, 4'hF, g, w);
    slv_issue(1'b1, 32'h1104, 32'h22, 4'hF, g, w);
    slv_issue(1'b0, 32'h2000, 32'h0, 4'hF, g, w);
    wait_rsp("read_0x2000_rsp");

    // Randomised mix of writes and reads over a small address window.
    max_lat = 3;
    for (int i = 0; i < 60; i++) begin
      gnt_pct = $urandom_range(30, 100);
      a  = 32'h4000 + 32'(4 * $urandom_range(0, 7));
      rd = ($urandom_range(0, 99) < 25);
      if (rd) begin
        slv_issue(1'b0, a, 32'h0, 4'hF, g, w);
        wait_rsp("rand_read_rsp");
      end else begin
        slv_issue(1'b1, a, $urandom, 4'($urandom_range(1, 15)), g, w);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    gnt_pct = 100;
    wait_drain("drain_random");

    // Reset with four buffered writes and the FSM in WR_REQ.
    set_gnt(0);
    max_lat = 0;
    for (int i = 0; i < 4; i++) slv_issue(1'b1, 32'h3000 + 32'(4 * i), 32'h30 + 32'(i), 4'hF, g, w);
    begin
      int n = 0;
      while (!(mst_req.req && slv_q.size() == 0) && n < Budget) begin
        @(negedge clk);
        n++;
      end
    end
    check("rst_setup_in_wr_req", 64'(mst_req.req), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_slv_rsp_zero", 64'(slv_rsp == '0), 64'(1));
    check("midrst_mst_req_zero", 64'(mst_req == '0), 64'(1));
    check("midrst_empty", 64'(empty), 64'(1));
    check("midrst_full", 64'(full), 64'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;
    mst_q.delete();
    slv_q.delete();
    for (int i = 0; i < 4; i++) ref_mem.delete(32'h3000 + 32'(4 * i));
    wr_accepted = 0;
    wr_done = 0;
    gnt_pct = 100;
    mst_req_cycles = 0;
    repeat (20) @(negedge clk);
    check("no_mst_req_after_reset", 64'(mst_req_cycles), 64'(0));
    check("empty_after_reset", 64'(empty), 64'(1));
`ifdef SL_WBUF_HWM_EN
    check("hwm_after_reset", 64'(hwm), 64'(0));
`endif
    @(posedge clk);
    #1;

    // Fill to five entries, then drain.
    set_gnt(0);
    for (int i = 0; i < 5; i++) slv_issue(1'b1, 32'h5000 + 32'(4 * i), 32'h50 + 32'(i), 4'h3, g, w);
    gnt_pct = 100;
    wait_drain("drain_hwm");
`ifdef SL_WBUF_HWM_EN
    check("hwm_after_drain", 64'(hwm), 64'(5));
`endif
    check("final_empty", 64'(empty), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sl_obi_write_buffer.md
SL_OBI_WRITE_BUFFER -- requirements
Module: sl_obi_write_buffer

Interface
REQ-001 SHALL have parameter obi_req_t, default logic: OBI request struct (req, addr, we, be, wdata).
REQ-002 SHALL have parameter obi_resp_t, default logic: OBI response struct (gnt, rvalid, rdata).
REQ-003 SHALL have parameter Depth, default 8: write FIFO entries, power of two, >=2.
REQ-004 SHALL have parameter AddrWidth, default 32: OBI address width.
REQ-005 SHALL have parameter DataWidth, default 32: OBI data width; BE width = DataWidth/8.
REQ-006 SHALL have port clk_i  input  1  sole clock.
REQ-007 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-008 SHALL have port slv_req_i  input  obi_req_t  request from core/DMA.
REQ-009 SHALL have port slv_rsp_o  output  obi_resp_t  response to core/DMA.
REQ-010 SHALL have port mst_req_o  output  obi_req_t  request to the serial-link wrapper OBI port.
REQ-011 SHALL have port mst_rsp_i  input  obi_resp_t  response from the serial-link wrapper.
REQ-012 SHALL have port empty_o  output  1  FIFO empty and master FSM in IDLE.
REQ-013 SHALL have port full_o  output  1  FIFO holds Depth entries.

Function
REQ-014 SHALL accept a slave write (req & we) with slv_rsp_o.gnt in the same cycle iff count < Depth and no read is pending; accepted {addr, be, wdata} is pushed.
REQ-015 SHALL post writes: slv_rsp_o.rvalid asserted exactly one cycle after each write gnt, rdata = 0.
REQ-016 SHALL grant a slave read (req & ~we) only when FIFO empty and master FSM IDLE; reads are never buffered.
REQ-017 SHALL hold slave read gnt low while writes drain; read is forwarded to master in the cycle empty_o is high.
REQ-018 SHALL return read data by passing mst_rsp_i.rvalid/rdata to slv_rsp_o in the same cycle (combinational path) while in RD_RESP.
REQ-019 SHALL run master FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP; one outstanding master transaction.
REQ-020 SHALL transition IDLE->WR_REQ when FIFO non-empty; IDLE->RD_REQ on pending slave read with FIFO empty; WR_REQ->WR_RESP on mst gnt (pop head); WR_RESP->IDLE on mst rvalid; RD_REQ->RD_RESP on mst gnt; RD_RESP->IDLE on mst rvalid.
REQ-021 SHALL drive mst_req_o.req high and all request fields stable in WR_REQ/RD_REQ until gnt.
REQ-022 SHALL decide push admission on the registered count: push when full is refused even if a pop occurs the same cycle.
REQ-023 SHALL update count by +1 (push only), -1 (pop only), 0 (push and pop); width $clog2(Depth+1).
REQ-024 SHALL wrap read/write pointers modulo Depth without extra logic (power-of-two depth).
REQ-025 SHALL preserve write order; write data reaches master in push order.

Reset
REQ-026 SHALL on rst_ni low: FSM IDLE, pointers/count 0, slv_rsp_o and mst_req_o all zero, empty_o=1, full_o=0.
REQ-027 SHALL discard buffered and in-flight writes on reset mid-operation; no master request after release until a new push.

Configuration
REQ-028 SHALL, with SL_WBUF_HWM_EN defined, add output hwm_o ($clog2(Depth+1) bits): maximum count since reset, updated the cycle after count rises above it.
REQ-029 SHALL, without SL_WBUF_HWM_EN, have no hwm_o port and no high-water register.

Structure
REQ-030 SHALL place FSM state enum and FIFO entry struct typedef in shared package sl_obi_wbuf_pkg.
REQ-031 SHALL implement storage as one sub-module sl_obi_wbuf_fifo (push/pop, count, full, empty); FSM in top.

Verification
REQ-032 SHALL verify: 3 writes (0x1000,0x1004,0x1008; data 0xA,0xB,0xC) with mst gnt always 1 -> slave gnt same cycle, rvalid +1 cycle, master sees same order.
REQ-033 SHALL verify: mst gnt held 0, 9 writes with Depth=8 -> gnts 1..8, full_o=1, 9th stalls until first master gnt plus one cycle.
REQ-034 SHALL verify: 2 writes then read 0x2000 -> read gnt only after second write's mst rvalid; mst returns 0x55 -> slv rdata 0x55 same cycle.
REQ-035 SHALL verify: rst_ni low for 1 cycle with 4 entries and FSM in WR_REQ -> all outputs at reset values, no further master requests.
REQ-036 SHALL verify: SL_WBUF_HWM_EN, fill to 5 then drain -> hwm_o=5 after drain.
